// File: rtl/game_sequencer.sv
// Top-level game step sequencer: waits on video frames, hands the movement
// turn to the pacman unit and then to each ghost unit in turn, evaluates the
// collision / pellet status and runs the death, win and lose flows.
`timescale 1ns/1ps
module game_sequencer #(
    parameter int NUM_GHOSTS = 4,
    parameter int MOVE_DIV   = 4,
    parameter int LIVES      = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ack,
    input  logic       frame_tick,
    input  logic       pac_done,
    input  logic       ghost_done,
    input  logic       collision,
    input  logic       pellets_zero,
    output logic       pac_go,
    output logic       ghost_go,
    output logic [1:0] ghost_sel,
    output logic       respawn,
    output logic [1:0] lives,
    output logic [7:0] state_oh,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_PAC_MOVE   = 3'd2,
        ST_GHOST_MOVE = 3'd3,
        ST_CHECK      = 3'd4,
        ST_DEATH      = 3'd5,
        ST_WIN        = 3'd6,
        ST_LOSE       = 3'd7
    } state_t;

    // Parameter-derived compare constants, sized to the counters they meet.
    localparam logic [3:0] MOVE_LAST    = 4'(MOVE_DIV - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] GHOST_LAST   = 2'(NUM_GHOSTS - 1);
    localparam logic [1:0] LIVES_INIT   = 2'(LIVES);

    // One-hot encoding of a state for the externally visible state vector.
    function automatic logic [7:0] onehot_of(input state_t st);
        logic [7:0] oh;
        case (st)
            ST_IDLE:       oh = 8'b0000_0001;
            ST_WAIT_FRAME: oh = 8'b0000_0010;
            ST_PAC_MOVE:   oh = 8'b0000_0100;
            ST_GHOST_MOVE: oh = 8'b0000_1000;
            ST_CHECK:      oh = 8'b0001_0000;
            ST_DEATH:      oh = 8'b0010_0000;
            ST_WIN:        oh = 8'b0100_0000;
            ST_LOSE:       oh = 8'b1000_0000;
            default:       oh = 8'b0000_0001;
        endcase
        return oh;
    endfunction

    state_t     state_r,     state_s;
    logic [7:0] state_oh_r;
    logic [3:0] frame_cnt_r, frame_cnt_s;
    logic [7:0] wait_cnt_r,  wait_cnt_s;
    logic [1:0] ghost_sel_r, ghost_sel_s;
    logic [1:0] lives_r,     lives_s;
    logic       err_r,       err_s;
    logic       pac_go_r,    pac_go_s;
    logic       ghost_go_r,  ghost_go_s;
    logic       respawn_r,   respawn_s;

    // Handshake qualifiers: a done pulse coinciding with its go pulse is
    // discarded, and the wait counter reaching its last value forces progress.
    logic pac_done_ok_s;
    logic ghost_done_ok_s;
    logic timeout_s;

    assign pac_done_ok_s   = pac_done   & ~pac_go_r;
    assign ghost_done_ok_s = ghost_done & ~ghost_go_r;
    assign timeout_s       = (wait_cnt_r == TIMEOUT_LAST);

    // Next-state, counter and go-pulse decisions for the sequencer.
    always_comb begin
        state_s     = state_r;
        frame_cnt_s = frame_cnt_r;
        wait_cnt_s  = 8'd0;
        ghost_sel_s = ghost_sel_r;
        lives_s     = lives_r;
        err_s       = err_r;
        pac_go_s    = 1'b0;
        ghost_go_s  = 1'b0;
        respawn_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                lives_s     = LIVES_INIT;
                frame_cnt_s = 4'd0;
                err_s       = 1'b0;
                ghost_sel_s = 2'd0;
                if (start) begin
                    state_s = ST_WAIT_FRAME;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_WAIT_FRAME: begin
                if (frame_tick) begin
                    if (frame_cnt_r == MOVE_LAST) begin
                        state_s     = ST_PAC_MOVE;
                        frame_cnt_s = 4'd0;
                        pac_go_s    = 1'b1;
                    end else begin
                        frame_cnt_s = frame_cnt_r + 4'd1;
                    end
                end else begin
                    state_s = ST_WAIT_FRAME;
                end
            end

            ST_PAC_MOVE: begin
                if (pac_done_ok_s || timeout_s) begin
                    // A timeout counts as a done but is latched as an error.
                    if (!pac_done_ok_s) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    state_s     = ST_GHOST_MOVE;
                    ghost_sel_s = 2'd0;
                    ghost_go_s  = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end

            ST_GHOST_MOVE: begin
                if (ghost_done_ok_s || timeout_s) begin
                    if (!ghost_done_ok_s) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    if (ghost_sel_r == GHOST_LAST) begin
                        state_s = ST_CHECK;
                    end else begin
                        // ghost_sel moves together with the new go pulse so it
                        // is stable from go through the matching done.
                        ghost_sel_s = ghost_sel_r + 2'd1;
                        ghost_go_s  = 1'b1;
                    end
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end

            ST_CHECK: begin
                if (collision) begin
                    if (lives_r == 2'd1) begin
                        state_s = ST_LOSE;
                        lives_s = 2'd0;
                    end else begin
                        state_s   = ST_DEATH;
                        lives_s   = lives_r - 2'd1;
                        respawn_s = 1'b1;
                    end
                end else if (pellets_zero) begin
                    state_s = ST_WIN;
                end else begin
                    state_s = ST_WAIT_FRAME;
                end
            end

            ST_DEATH: begin
                if (frame_tick) begin
                    state_s     = ST_WAIT_FRAME;
                    frame_cnt_s = 4'd0;
                end else begin
                    state_s = ST_DEATH;
                end
            end

            ST_WIN, ST_LOSE: begin
                if (ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and all outputs are registered; reset forces IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            state_oh_r  <= 8'b0000_0001;
            frame_cnt_r <= 4'd0;
            wait_cnt_r  <= 8'd0;
            ghost_sel_r <= 2'd0;
            lives_r     <= 2'd0;
            err_r       <= 1'b0;
            pac_go_r    <= 1'b0;
            ghost_go_r  <= 1'b0;
            respawn_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            state_oh_r  <= onehot_of(state_s);
            frame_cnt_r <= frame_cnt_s;
            wait_cnt_r  <= wait_cnt_s;
            ghost_sel_r <= ghost_sel_s;
            lives_r     <= lives_s;
            err_r       <= err_s;
            pac_go_r    <= pac_go_s;
            ghost_go_r  <= ghost_go_s;
            respawn_r   <= respawn_s;
        end
    end

    assign pac_go      = pac_go_r;
    assign ghost_go    = ghost_go_r;
    assign ghost_sel   = ghost_sel_r;
    assign respawn     = respawn_r;
    assign lives       = lives_r;
    assign state_oh    = state_oh_r;
    assign err_timeout = err_r;

endmodule
